// File: rtl/uart_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Package     : uart_pkg                                                 |
// | Description : Shared definitions for the uart transmit arbiter:        |
// |               default parameters, FSM state encoding and a clog2       |
// |               helper used to size index and counter fields.            |
// | Revision    : 1.0  initial release                                     |
// +------------------------------------------------------------------------+
package uart_pkg;

  localparam int c_nreq_default    = 4;
  localparam int c_hold_to_default = 1023;

  localparam logic [1:0] c_st_idle   = 2'd0;
  localparam logic [1:0] c_st_send   = 2'd1;
  localparam logic [1:0] c_st_settle = 2'd2;
  localparam logic [1:0] c_st_drain  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE   = c_st_idle,
    ST_SEND   = c_st_send,
    ST_SETTLE = c_st_settle,
    ST_DRAIN  = c_st_drain
  } state_t;

  // Number of bits needed to hold values 0..value-1.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rr_pick.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : uart_rr_pick                                             |
// | Description : Combinational rotating-priority picker. Returns the      |
// |               first set request found searching upward from ptr,       |
// |               wrapping past NREQ-1 back to 0.                          |
// | Ports       : req  in  NREQ   request vector                           |
// |               ptr  in  IDX_W  index holding highest priority           |
// |               idx  out IDX_W  chosen index (0 when any=0)              |
// |               any  out 1      at least one request set                 |
// | Revision    : 1.0  initial release                                     |
// +------------------------------------------------------------------------+
module uart_rr_pick #(
  parameter int NREQ  = 4,
  parameter int IDX_W = 2
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  always_comb begin
    idx = '0;
    any = 1'b0;
    // Walk offsets from farthest to nearest: the nearest set request
    // (counting up from ptr) makes the final assignment and wins.
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req[IDX_W'((int'(ptr) + k) % NREQ)]) begin
        idx = IDX_W'((int'(ptr) + k) % NREQ);
        any = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : uart_tx_arbiter                                          |
// | Description : Shares one uart transmitter among NREQ byte-stream       |
// |               requesters, round-robin per message (run of bytes        |
// |               ending with req_last). Writes are paced against          |
// |               uart_tx_busy; a granted requester idle for HOLD_TO       |
// |               cycles mid-message loses the grant (abort pulse).        |
// | Ports       : clk_50m, rst (async, active-high)                        |
// |               req/req_data/req_last  in   per-requester byte offer     |
// |               req_ack                out  one-cycle accept pulse       |
// |               grant_id, busy         out  current owner / in message   |
// |               abort                  out  timeout pulse                |
// |               uart_din, uart_wr_en   out  to transmitter               |
// |               uart_tx_busy           in   from transmitter             |
// | Revision    : 1.0  initial release                                     |
// +------------------------------------------------------------------------+
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter  int NREQ    = c_nreq_default,
  parameter  int HOLD_TO = c_hold_to_default,
  localparam int IDX_W   = clog2(NREQ),
  localparam int TO_W    = clog2(HOLD_TO + 1)
) (
  input  logic              clk_50m,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [8*NREQ-1:0] req_data,
  input  logic [NREQ-1:0]   req_last,
  output logic [NREQ-1:0]   req_ack,
  output logic [IDX_W-1:0]  grant_id,
  output logic              busy,
  output logic              abort,
  output logic [7:0]        uart_din,
  output logic              uart_wr_en,
  input  logic              uart_tx_busy
);

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  rr_q, rr_d;
  logic [TO_W-1:0]   timeout_q, timeout_d;
  logic              last_flag_q, last_flag_d;
  logic [IDX_W-1:0]  grant_q, grant_d;
  logic              busy_q, busy_d;
  logic              abort_q, abort_d;
  logic [NREQ-1:0]   ack_q, ack_d;
  logic [7:0]        din_q, din_d;
  logic              wr_en_q, wr_en_d;

  logic [7:0]        w_data_arr [NREQ];
  logic [IDX_W-1:0]  w_pick_idx;
  logic              w_pick_any;
  logic [IDX_W-1:0]  w_rr_next;

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_unpack_data
      assign w_data_arr[gi] = req_data[8*gi +: 8];
    end
  endgenerate

  uart_rr_pick #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .req (req),
    .ptr (rr_q),
    .idx (w_pick_idx),
    .any (w_pick_any)
  );

  // Priority after a message (finished or aborted) starts just past its owner.
  assign w_rr_next = (grant_q == IDX_W'(NREQ - 1)) ? '0 : grant_q + 1'b1;

  always_comb begin
    state_d     = state_q;
    rr_d        = rr_q;
    timeout_d   = timeout_q;
    last_flag_d = last_flag_q;
    grant_d     = grant_q;
    busy_d      = busy_q;
    abort_d     = 1'b0;
    ack_d       = '0;
    din_d       = din_q;
    wr_en_d     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (w_pick_any) begin
          grant_d   = w_pick_idx;
          busy_d    = 1'b1;
          timeout_d = '0;
          state_d   = ST_SEND;
        end
      end

      ST_SEND: begin
        if (req[grant_q]) begin
          // Owner is present; only the transmitter can hold us back, and
          // that is not the owner's fault, so the timeout stays cleared.
          timeout_d = '0;
          if (!uart_tx_busy) begin
            din_d          = w_data_arr[grant_q];
            wr_en_d        = 1'b1;
            ack_d[grant_q] = 1'b1;
            last_flag_d    = req_last[grant_q];
            state_d        = ST_SETTLE;
          end
        end else if (timeout_q == TO_W'(HOLD_TO - 1)) begin
          // HOLD_TO-th consecutive cycle without a byte from the owner.
          abort_d   = 1'b1;
          busy_d    = 1'b0;
          rr_d      = w_rr_next;
          timeout_d = '0;
          state_d   = ST_IDLE;
        end else begin
          timeout_d = timeout_q + 1'b1;
        end
      end

      // The transmitter raises tx_busy one cycle after wr_en; skip that
      // cycle so DRAIN never mistakes the pre-rise low for completion.
      ST_SETTLE: state_d = ST_DRAIN;

      ST_DRAIN: begin
        if (!uart_tx_busy) begin
          if (last_flag_q) begin
            busy_d  = 1'b0;
            rr_d    = w_rr_next;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_SEND;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_50m or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      rr_q        <= '0;
      timeout_q   <= '0;
      last_flag_q <= 1'b0;
      grant_q     <= '0;
      busy_q      <= 1'b0;
      abort_q     <= 1'b0;
      ack_q       <= '0;
      din_q       <= '0;
      wr_en_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      timeout_q   <= timeout_d;
      last_flag_q <= last_flag_d;
      grant_q     <= grant_d;
      busy_q      <= busy_d;
      abort_q     <= abort_d;
      ack_q       <= ack_d;
      din_q       <= din_d;
      wr_en_q     <= wr_en_d;
    end
  end

  assign req_ack    = ack_q;
  assign grant_id   = grant_q;
  assign busy       = busy_q;
  assign abort      = abort_q;
  assign uart_din   = din_q;
  assign uart_wr_en = wr_en_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : tb_uart_tx_arbiter                                       |
// | Description : Self-checking bench for uart_tx_arbiter. Requesters hold |
// |               queues of random messages; a message-level round-robin   |
// |               model predicts the byte stream seen by a uart model.     |
// | Revision    : 1.0  initial release                                     |
// +------------------------------------------------------------------------+
module tb_uart_tx_arbiter;

  localparam int NREQ    = 4;
  localparam int HOLD_TO = 8;
  localparam int DEPTH   = 256;

  logic        clk_50m = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  req_last;
  logic [3:0]  req_ack;
  logic [1:0]  grant_id;
  logic        busy;
  logic        abort;
  logic [7:0]  uart_din;
  logic        uart_wr_en;
  logic        uart_tx_busy;

  uart_tx_arbiter #(
    .NREQ    (NREQ),
    .HOLD_TO (HOLD_TO)
  ) dut (
    .clk_50m      (clk_50m),
    .rst          (rst),
    .req          (req),
    .req_data     (req_data),
    .req_last     (req_last),
    .req_ack      (req_ack),
    .grant_id     (grant_id),
    .busy         (busy),
    .abort        (abort),
    .uart_din     (uart_din),
    .uart_wr_en   (uart_wr_en),
    .uart_tx_busy (uart_tx_busy)
  );

  always #10 clk_50m = ~clk_50m;

  int n_pass = 0;
  int n_fail = 0;
  int n_total = 0;

  // Requester byte stores: {last, data}; head = next byte to offer.
  logic [8:0]  pmem [NREQ][DEPTH];
  int          phead [NREQ];
  int          ptail [NREQ];
  // Expected uart byte stream: {id, last, data}.
  logic [10:0] exp_q [$];

  int m_rr;
  int cyc = 0;
  int exp_abort_cyc = -1;
  int free_cyc = 0;
  int last_wr_cyc = -100;
  int tx_cnt = 0;
  int tx_len_fix = 0;
  bit rise_pend = 1'b0;
  bit prev_busy = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic push_byte(input int i, input bit last, input logic [7:0] d);
    pmem[i][ptail[i]] = {last, d};
    ptail[i]++;
  endtask

  task automatic add_msg(input int i, input int len);
    for (int b = 0; b < len; b++) push_byte(i, b == len - 1, 8'($urandom));
  endtask

  // Message-level round robin over everything pending: owner = first
  // requester with bytes, searching up from m_rr; its whole message goes
  // out, then priority moves past it.
  task automatic schedule();
    int h [NREQ];
    int g;
    bit done;
    logic [8:0] e;
    for (int i = 0; i < NREQ; i++) h[i] = phead[i];
    for (int guard = 0; guard < 64; guard++) begin
      g = -1;
      for (int k = NREQ - 1; k >= 0; k--) begin
        if (h[(m_rr + k) % NREQ] < ptail[(m_rr + k) % NREQ]) g = (m_rr + k) % NREQ;
      end
      if (g < 0) break;
      done = 1'b0;
      while (!done && h[g] < ptail[g]) begin
        e = pmem[g][h[g]];
        h[g]++;
        exp_q.push_back({2'(g), e});
        done = e[8];
      end
      m_rr = (g + 1) % NREQ;
    end
  endtask

  task automatic drive();
    for (int i = 0; i < NREQ; i++) begin
      if (phead[i] < ptail[i]) begin
        req[i]            = 1'b1;
        req_data[8*i +: 8] = pmem[i][phead[i]][7:0];
        req_last[i]       = pmem[i][phead[i]][8];
      end else begin
        req[i]            = 1'b0;
        req_data[8*i +: 8] = 8'($urandom);
        req_last[i]       = 1'($urandom);
      end
    end
  endtask

  task automatic tick();
    logic [10:0] e;
    logic [3:0]  exp_ack;
    @(posedge clk_50m);
    #1;
    cyc++;
    exp_ack = 4'b0000;
    if (!rst) begin
      if (uart_wr_en) begin
        // uart_tx_busy still holds the value the DUT saw at this edge.
        check("wr_while_tx_busy", uart_tx_busy, 0);
        check("wr_spacing", (cyc - last_wr_cyc) > 2, 1);
        last_wr_cyc = cyc;
        if (exp_q.size() == 0) begin
          check("unexpected_write", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("uart_din", uart_din, e[7:0]);
          check("grant_id", grant_id, e[10:9]);
          check("busy_at_write", busy, 1);
          exp_ack = 4'b0001 << e[10:9];
        end
      end
      check("req_ack", req_ack, exp_ack);
      check("abort", abort, cyc == exp_abort_cyc);
      if (prev_busy && !busy && !abort) check("busy_fall_tx_idle", uart_tx_busy, 0);
    end
    prev_busy = busy;
    // uart model: busy rises one cycle after the write, lasts tx_cnt cycles
    if (rise_pend) begin
      uart_tx_busy = 1'b1;
      tx_cnt = (tx_len_fix > 0) ? tx_len_fix : int'($urandom_range(1, 5));
      rise_pend = 1'b0;
    end else if (uart_tx_busy) begin
      tx_cnt--;
      if (tx_cnt <= 0) begin
        uart_tx_busy = 1'b0;
        free_cyc = cyc;
      end
    end
    if (uart_wr_en && !rst) rise_pend = 1'b1;
    for (int i = 0; i < NREQ; i++) begin
      if (req_ack[i] && phead[i] < ptail[i]) phead[i]++;
    end
    drive();
  endtask

  task automatic run_done(input string tag);
    int n;
    n = 0;
    while ((exp_q.size() > 0 || busy) && n < 3000) begin
      tick();
      n++;
    end
    check(tag, (exp_q.size() == 0) && !busy, 1);
  endtask

  task automatic expect_rest(input int i);
    for (int j = phead[i]; j < ptail[i]; j++) exp_q.push_back({2'(i), pmem[i][j]});
  endtask

  initial begin
    int n;
    rst = 1'b1;
    req = '0;
    req_data = '0;
    req_last = '0;
    uart_tx_busy = 1'b0;
    m_rr = 0;
    for (int i = 0; i < NREQ; i++) begin
      phead[i] = 0;
      ptail[i] = 0;
    end
    repeat (3) tick();
    check("rst_busy", busy, 0);
    check("rst_grant_id", grant_id, 0);
    check("rst_req_ack", req_ack, 0);
    check("rst_abort", abort, 0);
    check("rst_uart_din", uart_din, 0);
    check("rst_uart_wr_en", uart_wr_en, 0);
    rst = 1'b0;
    tick();

    // Single byte from requester 1
    push_byte(1, 1'b1, 8'hA5);
    schedule();
    drive();
    run_done("single_done");

    // Three-byte message from requester 0
    push_byte(0, 1'b0, 8'h11);
    push_byte(0, 1'b0, 8'h22);
    push_byte(0, 1'b1, 8'h33);
    schedule();
    drive();
    run_done("message_done");

    // Round robin from rr=0 with all four requesting: 0,1,2,3,0
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m_rr = 0;
    tick();
    add_msg(0, 1);
    add_msg(0, 1);
    add_msg(1, 1);
    add_msg(2, 1);
    add_msg(3, 1);
    schedule();
    drive();
    run_done("round_robin_done");

    // Random message mixes
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < NREQ; i++) begin
        if ($urandom_range(0, 1) == 1 || (i == r % NREQ)) begin
          add_msg(i, $urandom_range(1, 4));
          if ($urandom_range(0, 2) == 0) add_msg(i, $urandom_range(1, 4));
        end
      end
      schedule();
      drive();
      run_done("random_done");
    end

    // Transmitter busy far longer than HOLD_TO with req held: no abort
    uart_tx_busy = 1'b1;
    tx_cnt = 3 * HOLD_TO;
    add_msg(2, 2);
    schedule();
    drive();
    run_done("tx_hold_done");

    // Contention: requester 0 arrives while 2 owns the grant
    add_msg(2, 3);
    schedule();
    drive();
    n = 0;
    while (exp_q.size() > 2 && n < 200) begin
      tick();
      n++;
    end
    check("contention_first_byte", exp_q.size(), 2);
    add_msg(0, 2);
    expect_rest(0);
    m_rr = 1;
    drive();
    run_done("contention_done");

    // Timeout: owner 1 sends a non-final byte then goes silent
    push_byte(1, 1'b0, 8'h5C);
    schedule();
    drive();
    n = 0;
    while (exp_q.size() > 0 && n < 200) begin
      tick();
      n++;
    end
    check("timeout_byte_sent", exp_q.size(), 0);
    n = 0;
    while ((rise_pend || uart_tx_busy) && n < 200) begin
      tick();
      n++;
    end
    exp_abort_cyc = free_cyc + 1 + HOLD_TO;
    while (cyc <= exp_abort_cyc) tick();
    check("timeout_busy_low", busy, 0);
    exp_abort_cyc = -1;
    add_msg(1, 1);
    add_msg(2, 1);
    schedule();
    drive();
    run_done("after_abort_done");

    // Reset while draining a message from requester 3
    tx_len_fix = 6;
    add_msg(3, 3);
    schedule();
    drive();
    n = 0;
    while (exp_q.size() > 2 && n < 200) begin
      tick();
      n++;
    end
    check("reset_first_byte", exp_q.size(), 2);
    tick();
    tick();
    #5;
    rst = 1'b1;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_grant_id", grant_id, 0);
    check("mid_rst_req_ack", req_ack, 0);
    check("mid_rst_abort", abort, 0);
    check("mid_rst_uart_din", uart_din, 0);
    check("mid_rst_uart_wr_en", uart_wr_en, 0);
    prev_busy = 1'b0;
    exp_q.delete();
    for (int i = 0; i < NREQ; i++) phead[i] = ptail[i];
    m_rr = 0;
    drive();
    tick();
    tick();
    rst = 1'b0;
    tx_len_fix = 0;
    add_msg(0, 1);
    add_msg(2, 1);
    schedule();
    drive();
    run_done("post_reset_done");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
